// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: default parameter values,
// FSM state encodings and a helper for index width derivation.
package imem_pkg;

    // Default parameter values used by instr_mem_sync.
    localparam int unsigned IMEM_DATA_WIDTH_DEF  = 16;
    localparam int unsigned IMEM_ADDR_WIDTH_DEF  = 16;
    localparam int unsigned IMEM_DEPTH_DEF       = 1024;
    localparam int unsigned IMEM_CLEAR_VALUE_DEF = 0;

    // FSM state encodings (kept as plain constants for legacy compatibility).
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Number of index bits needed to address 'depth' words (at least one).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_ram_sp.sv
// Single-port word array: synchronous write, combinational read at the same
// address. The array carries no reset; its contents come only from writes.
module imem_ram_sp #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned IW         = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store write data at the addressed word on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Present the addressed word combinationally; the caller registers it.
    always_comb begin
        rdata_o = mem_q[addr_i];
    end

endmodule

// File: rtl/instr_mem_sync.sv
// Instruction memory with a power-up/reset clear sequence, one-cycle
// registered reads, write-first bypass and out-of-range access flagging.
module instr_mem_sync
    import imem_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH  = IMEM_DATA_WIDTH_DEF,
    parameter int unsigned            ADDR_WIDTH  = IMEM_ADDR_WIDTH_DEF,
    parameter int unsigned            DEPTH       = IMEM_DEPTH_DEF,
    parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = DATA_WIDTH'(IMEM_CLEAR_VALUE_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int unsigned             IW        = idx_width(DEPTH);
    localparam logic [IW-1:0]           LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]     DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [0:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  aerr_q, aerr_d;

    logic                  clearing;
    logic                  ready;
    logic                  in_range;
    logic [IW-1:0]         acc_idx;
    logic                  ram_we;
    logic [IW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Decode the current mode and the external access address.
    always_comb begin
        clearing = (state_q == ST_CLEAR);
        ready    = (state_q == ST_READY);
        in_range = ({1'b0, addr} < DEPTH_LIM);
        acc_idx  = addr[IW-1:0];
    end

    // Steer the single RAM port: the clear sweep owns it in CLEAR, the
    // external address owns it in READY. Reset blocks any write that cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = acc_idx;
        ram_wdata = data;
        if (clearing) begin
            ram_addr  = idx_q;
            ram_wdata = CLEAR_VALUE;
            ram_we    = !rst;
        end else begin
            ram_we    = !rst && we && in_range;
        end
    end

    imem_ram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Advance the clear index and leave CLEAR after the last word is written.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (clearing) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_READY;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + IW'(1);
            end
        end
    end

    // Form the next read result; same-address write data bypasses the array
    // so a simultaneous read sees the new word.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = ready && re;
        aerr_d   = ready && (re || we) && !in_range;
        if (ready && re) begin
            if (!in_range) begin
                rdata_d = '0;
            end else if (we) begin
                rdata_d = data;
            end else begin
                rdata_d = ram_rdata;
            end
        end
    end

    // Register FSM, clear index and read outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            idx_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            aerr_q   <= aerr_d;
        end
    end

    // Drive outputs from registered state.
    always_comb begin
        q        = rdata_q;
        q_valid  = rvalid_q;
        addr_err = aerr_q;
        busy     = clearing;
    end

endmodule

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, instruction word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, external address width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, word count; power of two, at most 2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter CLEAR_VALUE, default 0, word written to every location during clear.
REQ-005 The block SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port addr, input, ADDR_WIDTH, word address shared by read and write.
REQ-008 The block SHALL have port re, input, 1, read request.
REQ-009 The block SHALL have port we, input, 1, write request (program load).
REQ-010 The block SHALL have port data, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port q, output, DATA_WIDTH, registered read data.
REQ-012 The block SHALL have port q_valid, output, 1, one-cycle pulse qualifying q.
REQ-013 The block SHALL have port busy, output, 1, high while the clear sequence runs.
REQ-014 The block SHALL have port addr_err, output, 1, one-cycle pulse flagging an out-of-range access.

Function
REQ-015 The FSM SHALL have two states, CLEAR and READY; rst forces CLEAR with clear index 0.
REQ-016 In CLEAR, the block SHALL write CLEAR_VALUE to location index each cycle and then increment index; after writing DEPTH-1 it SHALL enter READY on the next edge, so busy stays high for exactly DEPTH cycles after rst falls.
REQ-017 In CLEAR, re and we SHALL be ignored, with no write, no q_valid and no addr_err.
REQ-018 busy SHALL equal 1 in CLEAR and 0 in READY.
REQ-019 Read latency SHALL be one cycle: re high in READY at edge N gives q and q_valid=1 after edge N+1; q holds its value when q_valid=0.
REQ-020 An address is in range when addr < DEPTH; the internal index SHALL be addr[log2(DEPTH)-1:0].
REQ-021 A write with we high in READY and addr in range SHALL update the location at that edge.
REQ-022 On same-cycle re and we to the same in-range address, q SHALL return the new data (write-first).
REQ-023 An out-of-range write SHALL be suppressed, with addr_err=1 for one cycle.
REQ-024 An out-of-range read SHALL return q=0 with q_valid=1 and addr_err=1 in the same cycle.
REQ-025 When re and we are both high to an out-of-range address, addr_err SHALL pulse only once.
REQ-026 Back-to-back reads SHALL sustain one result per cycle with no bubbles.

Reset
REQ-027 On rst the block SHALL set q=0, q_valid=0, addr_err=0, busy=1, state=CLEAR and index=0.
REQ-028 rst asserted mid-clear SHALL restart the clear from index 0.
REQ-029 rst asserted in READY SHALL discard any pending read, so no q_valid follows.
REQ-030 Memory contents SHALL be defined only by the clear sequence; the array itself has no reset.

Structure
REQ-031 The FSM state encodings and the default parameter values SHALL live in the shared package imem_pkg.
REQ-032 Storage SHALL be a sub-module imem_ram_sp, a single-port synchronous-write array; the FSM, clear counter, range check and output registers SHALL sit in instr_mem_sync.

Verification
REQ-033 With DEPTH=16, pulse rst for 1 cycle and then read all 16 addresses -> busy high for exactly 16 cycles after rst falls; every read returns 0x0000.
REQ-034 Write 0xBEEF to addr 5, then set re at addr 5 on the next cycle -> q=0xBEEF with q_valid one cycle later.
REQ-035 Set re and we together, addr 3, data 0x1234 -> q=0x1234 on the following cycle.
REQ-036 With DEPTH=16, write 0xAAAA to addr 0x0010, then read 0x0010 -> addr_err pulses twice, q=0 on the read, and addr 0 still reads 0x0000.
REQ-037 Set re and we together to out-of-range addr 0x0010 -> addr_err pulses exactly once, q=0, q_valid=1, no location changes.
REQ-038 Assert rst when index=7, hold re and we high throughout -> clear restarts at 0; busy high 16 more cycles after rst falls; no q_valid, no addr_err, no write lands during the clear.
